// File: rtl/sequencer_voice_pkg.sv
// Note codes, half-period table and helpers shared by the
// sequencer voice and its oscillator.
package sass_notes_pkg;

  typedef logic [3:0] note_t;

  localparam note_t OFF    = 4'd0;
  localparam note_t LOW_C  = 4'd1;
  localparam note_t CS     = 4'd2;
  localparam note_t D      = 4'd3;
  localparam note_t DS     = 4'd4;
  localparam note_t E      = 4'd5;
  localparam note_t F      = 4'd6;
  localparam note_t FS     = 4'd7;
  localparam note_t G      = 4'd8;
  localparam note_t GS     = 4'd9;
  localparam note_t A      = 4'd10;
  localparam note_t AS     = 4'd11;
  localparam note_t B      = 4'd12;
  localparam note_t HIGH_C = 4'd13;

  // Half-period in 10 kHz clocks; codes 0, 14, 15 never sound
  localparam logic [4:0] HALF_PERIOD [0:15] = '{
    5'd0,  5'd19, 5'd18, 5'd17,
    5'd16, 5'd15, 5'd14, 5'd14,
    5'd13, 5'd12, 5'd11, 5'd11,
    5'd10, 5'd10, 5'd0,  5'd0
  };

  typedef enum logic {
    ST_IDLE,
    ST_PLAYING
  } state_t;

  function automatic logic is_valid_note(
    input note_t n
  );
    return (n >= LOW_C) && (n <= HIGH_C);
  endfunction

endpackage

// File: rtl/sequencer_voice_if.sv
// Player note bus into the voice and the rendered
// audio/status signals back out.
interface sequencer_voice_if #(
  parameter int NUM_PLAYERS = 8
);

  logic                     sequencer_on;
  logic [4*NUM_PLAYERS-1:0] notes_in;
  logic                     tone_out;
  logic [3:0]               note_out;
  logic                     active;

  modport master (
    output sequencer_on,
    output notes_in,
    input  tone_out,
    input  note_out,
    input  active
  );

  modport slave (
    input  sequencer_on,
    input  notes_in,
    output tone_out,
    output note_out,
    output active
  );

endinterface

// File: rtl/sequencer_voice_tone_osc.sv
// Square-wave oscillator: load restarts high with a fresh
// half-period, run counts down and toggles on expiry.
module tone_osc (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] half_period,
  input  logic       run,
  output logic       tone
);

  logic [4:0] r_ph;
  logic       r_tone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph   <= '0;
      r_tone <= 1'b0;
    end else if (load) begin
      r_ph   <= half_period - 5'd1;
      r_tone <= 1'b1;
    end else if (run) begin
      if (r_ph == 5'd0) begin
        r_ph   <= half_period - 5'd1;
        r_tone <= ~r_tone;
      end else begin
        r_ph <= r_ph - 5'd1;
      end
    end
  end

  assign tone = r_tone;

endmodule

// File: rtl/sequencer_voice.sv
// Picks the lowest-index valid player note, strikes it on
// change, and sustains it as a square-wave tone.
module sequencer_voice
  import sass_notes_pkg::*;
#(
  parameter int NUM_PLAYERS    = 8,
  parameter int SUSTAIN_CYCLES = 2500
) (
  input logic              clk,
  input logic              rst,
  sequencer_voice_if.slave bus
);

  localparam int SW = $clog2(SUSTAIN_CYCLES + 1);
  localparam logic [SW-1:0] SUS_LOAD = SW'(SUSTAIN_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  note_t         r_note;
  note_t         r_prev;
  note_t         w_sel;
  logic [SW-1:0] r_sus;
  logic          w_strike;
  logic          w_sus_zero;
  logic          w_load;
  logic          w_run;
  logic [4:0]    w_half;
  logic          w_tone;

  // Descending scan so the lowest index is written last and wins
  always_comb begin
    w_sel = OFF;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (is_valid_note(bus.notes_in[4*i +: 4])) begin
        w_sel = bus.notes_in[4*i +: 4];
      end
    end
  end

  assign w_strike = bus.sequencer_on
                 && (w_sel != OFF)
                 && (w_sel != r_prev);

  assign w_sus_zero = (r_sus == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!bus.sequencer_on) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_strike) w_next = ST_PLAYING;
        end
        ST_PLAYING: begin
          if (!w_strike && w_sus_zero) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load = w_strike;
    w_run  = (r_state == ST_PLAYING) && !w_strike;
    w_half = w_strike ? HALF_PERIOD[w_sel]
                      : HALF_PERIOD[r_note];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note <= OFF;
      r_prev <= OFF;
      r_sus  <= '0;
    end else begin
      r_prev <= bus.sequencer_on ? w_sel : OFF;
      if (w_next == ST_IDLE) begin
        r_note <= OFF;
        r_sus  <= '0;
      end else if (w_strike) begin
        r_note <= w_sel;
        r_sus  <= SUS_LOAD;
      end else if (!w_sus_zero) begin
        r_sus <= r_sus - 1'b1;
      end
    end
  end

  tone_osc u_osc (
    .clk         (clk),
    .rst         (rst),
    .load        (w_load),
    .half_period (w_half),
    .run         (w_run),
    .tone        (w_tone)
  );

  // Oscillator state is stale while idle; gate it off here
  assign bus.active   = (r_state == ST_PLAYING);
  assign bus.note_out = r_note;
  assign bus.tone_out = (r_state == ST_PLAYING) && w_tone;

endmodule

// File: tb/tb_sequencer_voice.sv
// Randomized and directed bench for sequencer_voice against
// a behavioural note-age model (sustain 2500 and 1).
module tb_sequencer_voice;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sequencer_voice_if #(.NUM_PLAYERS(8)) bus0 ();
  sequencer_voice_if #(.NUM_PLAYERS(8)) bus1 ();

  sequencer_voice #(
    .NUM_PLAYERS    (8),
    .SUSTAIN_CYCLES (2500)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sequencer_voice #(
    .NUM_PLAYERS    (8),
    .SUSTAIN_CYCLES (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks   = 0;
  int failures = 0;

  int half_tbl [0:15] = '{0, 19, 18, 17, 16, 15, 14, 14,
                          13, 12, 11, 11, 10, 10, 0, 0};

  typedef struct {
    bit play;
    int note;
    int age;
    int prev;
  } mdl_t;

  mdl_t m0;
  mdl_t m1;

  function automatic mdl_t mreset();
    mdl_t r;
    r.play = 1'b0;
    r.note = 0;
    r.age  = 0;
    r.prev = 0;
    return r;
  endfunction

  function automatic int pick(input logic [31:0] n);
    int sel;
    int c;
    sel = 0;
    for (int i = 7; i >= 0; i--) begin
      c = int'((n >> (4 * i)) & 32'hF);
      if (c >= 1 && c <= 13) sel = c;
    end
    return sel;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit on,
                                input logic [31:0] n,
                                input int sus);
    mdl_t r;
    int sel;
    r   = m;
    sel = pick(n);
    if (!on) begin
      r.play = 1'b0;
    end else if (sel != 0 && sel != m.prev) begin
      r.play = 1'b1;
      r.note = sel;
      r.age  = 0;
    end else if (m.play) begin
      r.age = m.age + 1;
      if (r.age >= sus) r.play = 1'b0;
    end
    r.prev = on ? sel : 0;
    return r;
  endfunction

  function automatic int exp_tone(input mdl_t m);
    if (!m.play) return 0;
    return ((m.age / half_tbl[m.note]) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int exp_note(input mdl_t m);
    return m.play ? m.note : 0;
  endfunction

  function void chk(input string nm, input int act,
                    input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= mreset();
      m1 <= mreset();
    end else begin
      m0 <= step(m0, bus0.sequencer_on, bus0.notes_in, 2500);
      m1 <= step(m1, bus1.sequencer_on, bus1.notes_in, 1);
    end
  end

  always @(negedge clk) begin
    chk("d0_tone",   int'(bus0.tone_out), exp_tone(m0));
    chk("d0_note",   int'(bus0.note_out), exp_note(m0));
    chk("d0_active", int'(bus0.active),   int'(m0.play));
    chk("d1_tone",   int'(bus1.tone_out), exp_tone(m1));
    chk("d1_note",   int'(bus1.note_out), exp_note(m1));
    chk("d1_active", int'(bus1.active),   int'(m1.play));
  end

  task automatic set_in(input bit on, input logic [31:0] n);
    bus0.sequencer_on = on;
    bus1.sequencer_on = on;
    bus0.notes_in     = n;
    bus1.notes_in     = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic play_check(input string nm, input int note,
                            input int h, input int clr_at);
    int cnt;
    int cnt1;
    cnt  = 0;
    cnt1 = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (k == 0) begin
        chk({nm, "_note"},  int'(bus0.note_out), note);
        chk({nm, "_tone0"}, int'(bus0.tone_out), 1);
      end
      if (k == h - 1) chk({nm, "_tone_hm1"}, int'(bus0.tone_out), 1);
      if (k == h)     chk({nm, "_tone_h"},   int'(bus0.tone_out), 0);
      if (k == 2 * h) chk({nm, "_tone_2h"},  int'(bus0.tone_out), 1);
      if (bus1.active) cnt1++;
      if (k == clr_at) set_in(1'b1, 32'h0);
      if (!bus0.active) break;
      cnt++;
    end
    chk({nm, "_sustain"},  cnt,  2500);
    chk({nm, "_sustain1"}, cnt1, 1);
  endtask

  initial begin
    logic [31:0] n;
    int r;
    int hold;

    set_in(1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("rst_active", int'(bus0.active),   0);
    chk("rst_note",   int'(bus0.note_out), 0);

    // Codes 14/15 count as off
    set_in(1'b1, 32'h0000_E000);
    repeat (3) tick();
    chk("code14_active", int'(bus0.active), 0);
    set_in(1'b1, 32'h0000_F000);
    repeat (3) tick();
    chk("code15_active", int'(bus0.active), 0);
    set_in(1'b1, 32'h0);
    tick();

    // A on player 1 held 3 clocks
    set_in(1'b1, 32'h0000_00A0);
    play_check("A", 10, 11, 2);
    tick();

    // Player 0 lowC beats player 5 highC
    set_in(1'b1, 32'h00D0_0001);
    play_check("lowC", 1, 19, 2);
    tick();

    // Retrigger: A then E 100 clocks later
    set_in(1'b1, 32'h0000_00A0);
    repeat (100) tick();
    chk("A_before_retrig", int'(bus0.note_out), 10);
    set_in(1'b1, 32'h0000_0500);
    play_check("E_retrig", 5, 15, 2);
    tick();

    // Reset asserted mid-note
    set_in(1'b1, 32'h0000_0001);
    repeat (30) tick();
    chk("pre_rst_active", int'(bus0.active), 1);
    set_in(1'b1, 32'h0);
    rst = 1'b1;
    #1;
    chk("async_rst_tone",   int'(bus0.tone_out), 0);
    chk("async_rst_note",   int'(bus0.note_out), 0);
    chk("async_rst_active", int'(bus0.active),   0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_active", int'(bus0.active), 0);
    chk("post_rst_tone",   int'(bus0.tone_out), 0);

    // sequencer_on dropped mid-note, then restored
    set_in(1'b1, 32'h0000_0007);
    repeat (20) tick();
    set_in(1'b0, 32'h0000_0007);
    tick();
    chk("off_active", int'(bus0.active),   0);
    chk("off_note",   int'(bus0.note_out), 0);
    chk("off_tone",   int'(bus0.tone_out), 0);
    repeat (5) tick();
    set_in(1'b1, 32'h0000_0007);
    tick();
    chk("on_again_active", int'(bus0.active),   1);
    chk("on_again_note",   int'(bus0.note_out), 7);
    chk("on_again_tone",   int'(bus0.tone_out), 1);

    for (int s = 0; s < 40; s++) begin
      n = '0;
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(0, 9));
        if (r >= 8)
          n[4*i +: 4] = 4'($urandom_range(14, 15));
        else if (r >= 6)
          n[4*i +: 4] = 4'($urandom_range(1, 13));
      end
      hold = int'($urandom_range(1, 400));
      if ($urandom_range(0, 7) == 0) begin
        n    = '0;
        hold = int'($urandom_range(100, 2700));
      end
      set_in($urandom_range(0, 9) != 0, n);
      repeat (hold) tick();
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
